// File: rtl/rice_core_lsu_if.sv
// Memory bus between the load/store unit and the data memory.
// master: request (valid/address/write/strobe/data) out, ready and response in.
interface rice_core_lsu_if #(
    parameter int XLEN = 32
);
    logic            o_bus_request_valid;
    logic            i_bus_request_ready;
    logic [XLEN-1:0] o_bus_address;
    logic            o_bus_write;
    logic [3:0]      o_bus_strobe;
    logic [XLEN-1:0] o_bus_write_data;
    logic            i_bus_response_valid;
    logic [XLEN-1:0] i_bus_read_data;
    logic            i_bus_error;

    modport master (
        output o_bus_request_valid,
        input  i_bus_request_ready,
        output o_bus_address,
        output o_bus_write,
        output o_bus_strobe,
        output o_bus_write_data,
        input  i_bus_response_valid,
        input  i_bus_read_data,
        input  i_bus_error
    );

    modport slave (
        input  o_bus_request_valid,
        output i_bus_request_ready,
        input  o_bus_address,
        input  o_bus_write,
        input  o_bus_strobe,
        input  o_bus_write_data,
        output i_bus_response_valid,
        output i_bus_read_data,
        output i_bus_error
    );
endinterface

// File: rtl/rice_core_lsu.sv
// Load/store unit: one outstanding access, IDLE -> REQUEST -> RESPONSE.
// Ports: clk/rst, execute-side request (i_valid/o_ready, access, address,
// store data), completion (o_result_valid, o_load_data, o_misaligned,
// o_access_fault) and the memory bus interface (master modport).
module rice_core_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_memory_access,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_misaligned,
    output logic            o_access_fault,
    rice_core_lsu_if.master bus
);
    localparam logic [1:0] TYPE_LOAD  = 2'b01;
    localparam logic [1:0] TYPE_STORE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_t;

    state_t state;

    logic [1:0] access_type;
    logic [2:0] access_mode;
    logic       is_mem;
    logic       is_store;
    logic       reserved;
    logic       misaligned;
    logic [3:0] strobe_next;
    logic [31:0] wdata_next;

    // Only what load extension needs after the request has left.
    logic [1:0] addr_lo;
    logic [2:0] mode_q;

    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign access_type = i_memory_access[4:3];
    assign access_mode = i_memory_access[2:0];
    assign is_store    = access_type == TYPE_STORE;
    assign is_mem      = (access_type == TYPE_LOAD) || is_store;

    assign reserved = (access_mode == 3'b011) ||
                      (access_mode == 3'b110) ||
                      (access_mode == 3'b111);

    assign misaligned =
        ((access_mode[1:0] == 2'b01) && i_address[0]) ||
        ((access_mode[1:0] == 2'b10) && (i_address[1:0] != 2'b00));

    always_comb begin
        strobe_next = 4'b1111;
        wdata_next  = i_store_data;
        case (access_mode[1:0])
            2'b00: begin
                wdata_next = {4{i_store_data[7:0]}};
                if (is_store) strobe_next = 4'b0001 << i_address[1:0];
            end
            2'b01: begin
                wdata_next = {2{i_store_data[15:0]}};
                if (is_store) strobe_next = 4'b0011 << i_address[1:0];
            end
            default: begin
                wdata_next  = i_store_data;
                strobe_next = 4'b1111;
            end
        endcase
    end

    // Lane select then sign/zero extend; mode bit 2 marks unsigned loads.
    assign shifted = bus.i_bus_read_data >> {addr_lo, 3'b000};

    always_comb begin
        load_ext = bus.i_bus_read_data;
        case (mode_q[1:0])
            2'b00: load_ext = {{24{~mode_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = {{16{~mode_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_ext = bus.i_bus_read_data;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                   <= IDLE;
            o_ready                 <= 1'b1;
            o_result_valid          <= 1'b0;
            o_load_data             <= '0;
            o_misaligned            <= 1'b0;
            o_access_fault          <= 1'b0;
            bus.o_bus_request_valid <= 1'b0;
            bus.o_bus_address       <= '0;
            bus.o_bus_write         <= 1'b0;
            bus.o_bus_strobe        <= '0;
            bus.o_bus_write_data    <= '0;
            addr_lo                 <= '0;
            mode_q                  <= '0;
        end else begin
            o_result_valid <= 1'b0;
            o_load_data    <= '0;
            o_misaligned   <= 1'b0;
            o_access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (!is_mem) begin
                            o_result_valid <= 1'b1;
                        end else if (reserved) begin
                            o_result_valid <= 1'b1;
                            o_access_fault <= 1'b1;
                        end else if (misaligned) begin
                            o_result_valid <= 1'b1;
                            o_misaligned   <= 1'b1;
                        end else begin
                            state                   <= REQUEST;
                            o_ready                 <= 1'b0;
                            bus.o_bus_request_valid <= 1'b1;
                            bus.o_bus_address <= {i_address[31:2], 2'b00};
                            bus.o_bus_write         <= is_store;
                            bus.o_bus_strobe        <= strobe_next;
                            bus.o_bus_write_data    <= wdata_next;
                            addr_lo                 <= i_address[1:0];
                            mode_q                  <= access_mode;
                        end
                    end
                end
                REQUEST: begin
                    if (bus.i_bus_request_ready) begin
                        state                   <= RESPONSE;
                        bus.o_bus_request_valid <= 1'b0;
                    end
                end
                RESPONSE: begin
                    if (bus.i_bus_response_valid) begin
                        state          <= IDLE;
                        o_ready        <= 1'b1;
                        o_result_valid <= 1'b1;
                        o_access_fault <= bus.i_bus_error;
                        if (!bus.i_bus_error && !bus.o_bus_write)
                            o_load_data <= load_ext;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rice_core_lsu.sv
// Directed bench for rice_core_lsu with an access-level reference model
// and a per-cycle compare process.
module tb_rice_core_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [4:0]  mem_access = '0;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;
    logic        res_valid;
    logic [31:0] load_data;
    logic        mis;
    logic        flt;

    rice_core_lsu_if #(.XLEN(32)) bus ();

    rice_core_lsu #(.XLEN(32)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(valid),
        .o_ready(ready),
        .i_memory_access(mem_access),
        .i_address(addr),
        .i_store_data(sdata),
        .o_result_valid(res_valid),
        .o_load_data(load_data),
        .o_misaligned(mis),
        .o_access_fault(flt),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        uses_bus;
        logic [31:0] baddr;
        logic        bwrite;
        logic [3:0]  strb;
        logic [31:0] bwdata;
        logic [31:0] ld;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [31:0] last_baddr, last_wdata, last_ld;
    logic [3:0]  last_strb;
    logic        last_write, last_mis, last_flt;
    int          req_run = 0;
    int          last_req_run = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // What one access must do, from the access rules alone.
    function automatic exp_t model(input logic [1:0] t, input logic [2:0] m,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] rd, input logic err);
        exp_t   e;
        int     nb;
        int     off;
        longint v;
        longint mask;
        e   = '0;
        nb  = (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        if (!(t == 2'd1 || t == 2'd2)) return e;
        if (m == 3'd3 || m == 3'd6 || m == 3'd7) begin
            e.flt = 1'b1;
            return e;
        end
        if ((a % nb) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.uses_bus = 1'b1;
        e.baddr    = a - 32'(off);
        e.bwrite   = (t == 2'd2);
        e.strb     = e.bwrite ? 4'(((1 << nb) - 1) << off) : 4'hF;
        for (int i = 0; i < 4; i++)
            e.bwdata[8*i +: 8] = 8'(d >> (8 * (i % nb)));
        e.flt = err;
        if (t == 2'd1 && !err) begin
            v    = longint'(rd) >> (8 * off);
            mask = (longint'(1) << (8 * nb)) - 1;
            v    = v & mask;
            if (nb < 4 && !m[2] && (((v >> (8 * nb - 1)) & 1) == 1))
                v = v | ~mask;
            e.ld = 32'(v);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_rule", 32'(ready),
                32'(exp_q.size() == 0 || res_valid));
            if (bus.o_bus_request_valid) begin
                req_run++;
                last_baddr = bus.o_bus_address;
                last_strb  = bus.o_bus_strobe;
                last_wdata = bus.o_bus_write_data;
                last_write = bus.o_bus_write;
                if (exp_q.size() == 0 || !exp_q[0].uses_bus) begin
                    chk("spurious_request", 32'(1), 32'(0));
                end else begin
                    chk("bus_addr", bus.o_bus_address, exp_q[0].baddr);
                    chk("bus_write", 32'(bus.o_bus_write),
                        32'(exp_q[0].bwrite));
                    chk("bus_strobe", 32'(bus.o_bus_strobe),
                        32'(exp_q[0].strb));
                    if (exp_q[0].bwrite)
                        chk("bus_wdata", bus.o_bus_write_data,
                            exp_q[0].bwdata);
                end
            end else if (req_run != 0) begin
                last_req_run = req_run;
                req_run = 0;
            end
            if (res_valid) begin
                last_ld  = load_data;
                last_mis = mis;
                last_flt = flt;
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("load_data", load_data, e.ld);
                    chk("misaligned", 32'(mis), 32'(e.mis));
                    chk("access_fault", 32'(flt), 32'(e.flt));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [1:0] t, input logic [2:0] m,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input logic err,
                          input int rdy_dly, input int rsp_dly);
        exp_t e;
        int   n;
        n = 0;
        while (!ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(1), 32'(0));
        e          = model(t, m, a, d, rd, err);
        valid      = 1'b1;
        mem_access = {t, m};
        addr       = a;
        sdata      = d;
        step();
        exp_q.push_back(e);
        valid      = 1'b0;
        mem_access = 5'b01010;
        addr       = $urandom;
        sdata      = $urandom;
        if (!e.uses_bus) begin
            chk("immediate_latency", 32'(res_valid), 32'(1));
        end else begin
            chk("request_latency", 32'(bus.o_bus_request_valid), 32'(1));
            for (int k = 0; k < rdy_dly; k++) begin
                bus.i_bus_response_valid = 1'b1;
                bus.i_bus_read_data      = $urandom;
                step();
                chk("request_held", 32'(bus.o_bus_request_valid), 32'(1));
            end
            bus.i_bus_response_valid = 1'b0;
            bus.i_bus_request_ready  = 1'b1;
            step();
            bus.i_bus_request_ready = 1'b0;
            repeat (rsp_dly) step();
            bus.i_bus_response_valid = 1'b1;
            bus.i_bus_read_data      = rd;
            bus.i_bus_error          = err;
            step();
            bus.i_bus_response_valid = 1'b0;
            bus.i_bus_read_data      = $urandom;
            bus.i_bus_error          = 1'b0;
            chk("response_latency", 32'(res_valid), 32'(1));
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.i_bus_request_ready  = 1'b0;
        bus.i_bus_response_valid = 1'b0;
        bus.i_bus_read_data      = '0;
        bus.i_bus_error          = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_result_valid", 32'(res_valid), 32'(0));
        chk("rst_req_valid", 32'(bus.o_bus_request_valid), 32'(0));
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_strobe", 32'(bus.o_bus_strobe), 32'(0));
        rst = 1'b0;

        access(2'd1, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0);
        chk("lb_strobe", 32'(last_strb), 32'hF);
        chk("lb_addr", last_baddr, 32'h1000);
        chk("lb_data", last_ld, 32'hFFFF_FF80);

        access(2'd2, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b0, 0, 1);
        chk("sh_strobe", 32'(last_strb), 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_write", 32'(last_write), 32'(1));
        chk("sh_ld", last_ld, 32'h0);

        access(2'd1, 3'b010, 32'h3001, 32'h0, 32'h0, 1'b0, 0, 0);
        chk("lw_mis", 32'(last_mis), 32'(1));

        access(2'd1, 3'b101, 32'h4000, 32'h0, 32'h1234_9ABC, 1'b0, 3, 0);
        chk("lhu_hold", 32'(last_req_run), 32'd4);
        chk("lhu_data", last_ld, 32'h0000_9ABC);

        access(2'd1, 3'b010, 32'h5000, 32'h0, 32'hFFFF_FFFF, 1'b1, 1, 2);
        chk("lw_err_flt", 32'(last_flt), 32'(1));
        chk("lw_err_ld", last_ld, 32'h0);

        access(2'd0, 3'b011, 32'h0001, 32'h1, 32'h0, 1'b0, 0, 0);
        access(2'd1, 3'b011, 32'h5001, 32'h0, 32'h0, 1'b0, 0, 0);
        chk("rsv_flt", 32'(last_flt), 32'(1));
        chk("rsv_mis", 32'(last_mis), 32'(0));
        access(2'd1, 3'b001, 32'h6002, 32'h0, 32'h8001_0000, 1'b0, 0, 0);
        access(2'd1, 3'b100, 32'h7001, 32'h0, 32'h0000_F200, 1'b0, 2, 0);
        access(2'd2, 3'b000, 32'h8003, 32'h5A, 32'h0, 1'b0, 0, 0);
        access(2'd2, 3'b010, 32'h9000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 2);
        access(2'd1, 3'b010, 32'hA004, 32'h0, 32'hCAFE_BABE, 1'b0, 0, 0);
        access(2'd2, 3'b001, 32'hB001, 32'h1234, 32'h0, 1'b0, 0, 0);
        access(2'd1, 3'b110, 32'hB000, 32'h0, 32'h0, 1'b0, 0, 0);

        // Abandon a load in RESPONSE, then answer it late.
        valid      = 1'b1;
        mem_access = {2'd1, 3'b010};
        addr       = 32'hC000;
        step();
        exp_q.push_back(model(2'd1, 3'b010, 32'hC000, 32'h0, 32'h0, 1'b0));
        valid = 1'b0;
        bus.i_bus_request_ready = 1'b1;
        step();
        bus.i_bus_request_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        step();
        chk("abort_ready", 32'(ready), 32'(1));
        chk("abort_result", 32'(res_valid), 32'(0));
        chk("abort_req", 32'(bus.o_bus_request_valid), 32'(0));
        rst = 1'b0;
        bus.i_bus_response_valid = 1'b1;
        bus.i_bus_read_data      = 32'h1111_1111;
        step();
        bus.i_bus_response_valid = 1'b0;
        chk("late_rsp_ignored", 32'(res_valid), 32'(0));
        step();

        access(2'd2, 3'b000, 32'h0000, 32'h77, 32'h0, 1'b0, 0, 0);
        chk("sb0_strobe", 32'(last_strb), 32'h1);
        chk("sb0_wdata", last_wdata, 32'h7777_7777);
        chk("sb0_addr", last_baddr, 32'h0);
        step();
        chk("drain", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rice_core_lsu.md
RICE_CORE_LSU -- requirements
Module: rice_core_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  access request from the execute stage.
REQ-005 SHALL have port o_ready  output  1  LSU can accept a request.
REQ-006 SHALL have port i_memory_access  input  5  {access_type[1:0], access_mode[2:0]}, encoded per rice_core_memory_access.
REQ-007 SHALL have port i_address  input  32  effective byte address.
REQ-008 SHALL have port i_store_data  input  32  rs2 value.
REQ-009 SHALL have port o_result_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port o_load_data  output  32  extended load result; 0 for non-loads.
REQ-011 SHALL have port o_misaligned  output  1  address misaligned for the access mode; qualified by o_result_valid.
REQ-012 SHALL have port o_access_fault  output  1  bus error or reserved mode; qualified by o_result_valid.
REQ-013 SHALL have ports o_bus_request_valid out 1, i_bus_request_ready in 1, o_bus_address out 32, o_bus_write out 1, o_bus_strobe out 4, o_bus_write_data out 32.
REQ-014 SHALL have ports i_bus_response_valid in 1, i_bus_read_data in 32, i_bus_error in 1.

Function
REQ-015 SHALL implement FSM states IDLE, REQUEST, RESPONSE.
REQ-016 o_ready SHALL be 1 only in IDLE; a request is accepted when i_valid && o_ready.
REQ-017 On acceptance, address, type, mode, and store data SHALL be registered; later changes on inputs SHALL have no effect.
REQ-018 Accepted type NONE SHALL complete next cycle: o_result_valid=1, o_load_data=0, both fault flags 0, no bus request, stay IDLE.
REQ-019 Misaligned access SHALL be H/HU with addr[0]=1, or W with addr[1:0]!=0; it SHALL complete next cycle with o_misaligned=1 and no bus request.
REQ-020 Reserved mode (3'b011, 3'b110, 3'b111) SHALL complete next cycle with o_access_fault=1 and no bus request; if also misaligned, only o_access_fault is set.
REQ-021 A legal aligned LOAD/STORE SHALL go IDLE->REQUEST; o_bus_request_valid=1 from the next cycle, with address/write/strobe/data held stable until i_bus_request_ready=1.
REQ-022 o_bus_address SHALL be {addr[31:2],2'b00}; o_bus_write SHALL be 1 for STORE and 0 for LOAD.
REQ-023 Store strobe SHALL be B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111. Load strobe SHALL be 4'b1111.
REQ-024 Store data SHALL be replicated: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
REQ-025 On REQUEST with i_bus_request_ready=1, the FSM SHALL go to RESPONSE; i_bus_response_valid SHALL be ignored outside RESPONSE.
REQ-026 On RESPONSE with i_bus_response_valid=1, the FSM SHALL go to IDLE, and o_result_valid SHALL pulse for exactly one cycle on the next cycle.
REQ-027 On completion, o_access_fault SHALL equal i_bus_error; on error, o_load_data SHALL be 0.
REQ-028 Load data SHALL select the byte or halfword at addr[1:0]; B/H SHALL be sign-extended, BU/HU zero-extended, and W passed through.
REQ-029 o_load_data SHALL be 0 for stores; the pulse for any completion SHALL coincide with IDLE, so a new request may be accepted in the same cycle as o_result_valid.
REQ-030 Back-to-back accepted requests SHALL never overlap; at most one access is outstanding.

Reset
REQ-031 i_rst=1 SHALL force IDLE and clear all outputs to 0 except o_ready, which SHALL be 1, on the next edge.
REQ-032 Reset in REQUEST or RESPONSE SHALL abandon the access with no o_result_valid; a late bus response SHALL be ignored.

Verification
REQ-033 LB at 0x1003, bus data 0x80FF_0000 -> strobe 4'b1111, addr 0x1000, o_load_data 0xFFFF_FF80.
REQ-034 SH at 0x2002, data 0x0000_ABCD -> strobe 4'b1100, wdata 0xABCD_ABCD, write=1, result pulse with load_data 0.
REQ-035 LW at 0x3001 -> no bus request, o_result_valid and o_misaligned=1 one cycle after accept.
REQ-036 LHU at 0x4000 with i_bus_request_ready held 0 for 3 cycles -> request signals stable for 4 cycles; bus data 0x1234_9ABC -> 0x0000_9ABC.
REQ-037 LW with i_bus_error=1 -> o_access_fault=1, o_load_data=0.
REQ-038 i_rst pulse while in RESPONSE -> IDLE, o_ready=1, no o_result_valid; next SB at 0x0 proceeds normally.
